// File: rtl/sad_me_pkg.sv
// Shared types and helpers for the motion-estimation SAD datapath.
// Holds default field widths, the tracker state encoding and the MV L1-magnitude helper.
package sad_me_pkg;

  localparam int unsigned SadWDefault = 13;
  localparam int unsigned MvWDefault  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  // |x| + |y| of sign-extended MV components; wide enough that -2^(W-1) is exact
  function automatic logic [32:0] mv_l1(input logic signed [31:0] x, input logic signed [31:0] y);
    logic [31:0] ax;
    logic [31:0] ay;
    ax = x[31] ? -x : x;
    ay = y[31] ? -y : y;
    return {1'b0, ax} + {1'b0, ay};
  endfunction

endpackage

// File: rtl/sad_min_lane.sv
// One partition of the minimum-SAD tracker: holds the best SAD and its MV.
// With SAD_MIN_TIE_MV_EN defined, equal SADs are broken by the smaller MV L1 magnitude.
module sad_min_lane
  import sad_me_pkg::*;
#(
  parameter int unsigned SAD_W = SadWDefault,
  parameter int unsigned MV_W  = MvWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_i,
  input  logic             accept_i,
  input  logic             first_i,
  input  logic [SAD_W-1:0] sad_i,
  input  logic [MV_W-1:0]  mv_x_i,
  input  logic [MV_W-1:0]  mv_y_i,
  output logic [SAD_W-1:0] min_sad_o,
  output logic [MV_W-1:0]  best_mv_x_o,
  output logic [MV_W-1:0]  best_mv_y_o
);

  logic [SAD_W-1:0] sad_q, sad_d;
  logic [MV_W-1:0]  mv_x_q, mv_x_d;
  logic [MV_W-1:0]  mv_y_q, mv_y_d;
  logic             better;

`ifdef SAD_MIN_TIE_MV_EN
  logic [32:0] cand_mag;
  logic [32:0] win_mag;
  assign cand_mag = mv_l1(32'(signed'(mv_x_i)), 32'(signed'(mv_y_i)));
  assign win_mag  = mv_l1(32'(signed'(mv_x_q)), 32'(signed'(mv_y_q)));
  assign better   = (sad_i < sad_q) || ((sad_i == sad_q) && (cand_mag < win_mag));
`else
  assign better = sad_i < sad_q;
`endif

  always_comb begin
    sad_d  = sad_q;
    mv_x_d = mv_x_q;
    mv_y_d = mv_y_q;
    if (init_i) begin
      sad_d  = '1;
      mv_x_d = '0;
      mv_y_d = '0;
    end else if (accept_i && (first_i || better)) begin
      sad_d  = sad_i;
      mv_x_d = mv_x_i;
      mv_y_d = mv_y_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_q  <= '1;
      mv_x_q <= '0;
      mv_y_q <= '0;
    end else begin
      sad_q  <= sad_d;
      mv_x_q <= mv_x_d;
      mv_y_q <= mv_y_d;
    end
  end

  assign min_sad_o   = sad_q;
  assign best_mv_x_o = mv_x_q;
  assign best_mv_y_o = mv_y_q;

endmodule

// File: rtl/sad_min_tracker.sv
// Per-partition minimum-SAD tracker over one search window with start/last framing.
// Optional macro SAD_MIN_TIE_MV_EN enables MV-magnitude tie-breaking in every lane.
module sad_min_tracker
  import sad_me_pkg::*;
#(
  parameter int unsigned NUM_PART = 32,
  parameter int unsigned SAD_W    = SadWDefault,
  parameter int unsigned MV_W     = MvWDefault,
  parameter int unsigned CNT_W    = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sad_valid,
  input  logic                      sad_last,
  input  logic [NUM_PART*SAD_W-1:0] sad_in,
  input  logic [MV_W-1:0]           mv_x,
  input  logic [MV_W-1:0]           mv_y,
  output logic [NUM_PART*SAD_W-1:0] min_sad,
  output logic [NUM_PART*MV_W-1:0]  best_mv_x,
  output logic [NUM_PART*MV_W-1:0]  best_mv_y,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          cand_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic             first_q, first_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // start wins over a same-cycle beat, so the beat is dropped
  assign accept = (state_q == StSearch) && sad_valid && !start;

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    done_d  = accept && sad_last;
    if (start) begin
      state_d = StSearch;
      first_d = 1'b1;
      cnt_d   = '0;
    end else if (accept) begin
      first_d = 1'b0;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (sad_last) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      first_q <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar p = 0; p < NUM_PART; p++) begin : g_lane
    sad_min_lane #(
      .SAD_W(SAD_W),
      .MV_W (MV_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_i     (start),
      .accept_i   (accept),
      .first_i    (first_q),
      .sad_i      (sad_in[p*SAD_W +: SAD_W]),
      .mv_x_i     (mv_x),
      .mv_y_i     (mv_y),
      .min_sad_o  (min_sad[p*SAD_W +: SAD_W]),
      .best_mv_x_o(best_mv_x[p*MV_W +: MV_W]),
      .best_mv_y_o(best_mv_y[p*MV_W +: MV_W])
    );
  end

  assign busy     = (state_q == StSearch);
  assign done     = done_q;
  assign cand_cnt = cnt_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker: directed scenarios plus randomized traffic
// against a window-history reference model.
module tb_sad_min_tracker;

  localparam int NP = 4;
  localparam int SW = 13;
  localparam int MW = 8;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SAD_MIN_TIE_MV_EN
  localparam bit TieEn = 1'b1;
`else
  localparam bit TieEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, sad_valid, sad_last;
  logic [NP*SW-1:0] sad_in;
  logic [MW-1:0]    mv_x, mv_y;
  logic [NP*SW-1:0] min_sad;
  logic [NP*MW-1:0] best_mv_x, best_mv_y;
  logic             busy, done;
  logic [CW-1:0]    cand_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: beats of the current window, state 0 idle / 1 search / 2 done
  logic [NP*SW-1:0] q_sad[$];
  logic [MW-1:0]    q_mx[$];
  logic [MW-1:0]    q_my[$];
  int               m_state = 0;
  int               m_cnt = 0;
  bit               m_done = 1'b0;

  always #5 clk = ~clk;

  sad_min_tracker #(
    .NUM_PART(NP),
    .SAD_W   (SW),
    .MV_W    (MW),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sad_valid(sad_valid),
    .sad_last (sad_last),
    .sad_in   (sad_in),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .min_sad  (min_sad),
    .best_mv_x(best_mv_x),
    .best_mv_y(best_mv_y),
    .busy     (busy),
    .done     (done),
    .cand_cnt (cand_cnt)
  );

  function automatic int l1(input logic [MW-1:0] x, input logic [MW-1:0] y);
    int a, b;
    a = int'($signed(x));
    b = int'($signed(y));
    return (a < 0 ? -a : a) + (b < 0 ? -b : b);
  endfunction

  // Winner of partition p: lowest SAD over the window, then (if enabled) lowest
  // MV magnitude, then earliest beat.
  function automatic void exp_lane(input int p, output logic [SW-1:0] s,
                                   output logic [MW-1:0] x, output logic [MW-1:0] y);
    logic [NP*SW-1:0] w;
    logic [SW-1:0]    ci;
    s = '1;
    x = '0;
    y = '0;
    for (int i = 0; i < q_sad.size(); i++) begin
      w  = q_sad[i];
      ci = w[p*SW +: SW];
      if (i == 0 || ci < s || (TieEn && ci == s && l1(q_mx[i], q_my[i]) < l1(x, y))) begin
        s = ci;
        x = q_mx[i];
        y = q_my[i];
      end
    end
  endfunction

  function automatic logic [NP*SW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {13'(d), 13'(c), 13'(b), 13'(a)};
  endfunction

  function automatic void model_reset();
    q_sad.delete();
    q_mx.delete();
    q_my.delete();
    m_state = 0;
    m_cnt   = 0;
    m_done  = 1'b0;
  endfunction

  // Drive one cycle from a negedge; returns at the following negedge.
  task automatic apply(input logic st, input logic v, input logic l, input logic [NP*SW-1:0] s,
                       input logic [MW-1:0] mx, input logic [MW-1:0] my);
    start     = st;
    sad_valid = v;
    sad_last  = l;
    sad_in    = s;
    mv_x      = mx;
    mv_y      = my;
    m_done    = 1'b0;
    if (st) begin
      q_sad.delete();
      q_mx.delete();
      q_my.delete();
      m_cnt   = 0;
      m_state = 1;
    end else if (m_state == 1 && v) begin
      q_sad.push_back(s);
      q_mx.push_back(mx);
      q_my.push_back(my);
      if (m_cnt < CMAX) m_cnt++;
      if (l) begin
        m_state = 2;
        m_done  = 1'b1;
      end
    end
    @(negedge clk);
    start     = 1'b0;
    sad_valid = 1'b0;
    sad_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    checks++; if (min_sad !== '1) begin errors++; $display("FAIL reset_min got %0h want all ones", min_sad); end
    checks++; if (best_mv_x !== '0) begin errors++; $display("FAIL reset_mvx got %0h want 0", best_mv_x); end
    checks++; if (best_mv_y !== '0) begin errors++; $display("FAIL reset_mvy got %0h want 0", best_mv_y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (cand_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cand_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    apply(1, 0, 0, '0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    apply(0, 1, 0, pack4(100, 50, 200, 7), 8'd1, 8'd1);
    apply(0, 1, 0, pack4(90, 60, 200, 8), 8'd2, 8'hFE);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b want 0", done); end
    apply(0, 1, 1, pack4(95, 40, 10, 9), 8'hFD, 8'd3);
    checks++; if (min_sad !== pack4(90, 40, 10, 7)) begin errors++; $display("FAIL basic_min got %0h want %0h", min_sad, pack4(90, 40, 10, 7)); end
    checks++; if (best_mv_x !== {8'd1, 8'hFD, 8'hFD, 8'd2}) begin errors++; $display("FAIL basic_mvx got %0h want 01fdfd02", best_mv_x); end
    checks++; if (best_mv_y !== {8'd1, 8'd3, 8'd3, 8'hFE}) begin errors++; $display("FAIL basic_mvy got %0h want 010303fe", best_mv_y); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy); end
    checks++; if (cand_cnt !== 3'd3) begin errors++; $display("FAIL basic_cnt got %0d want 3", cand_cnt); end
    apply(0, 0, 0, '0, 0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (min_sad !== pack4(90, 40, 10, 7)) begin errors++; $display("FAIL basic_hold got %0h want %0h", min_sad, pack4(90, 40, 10, 7)); end
  endtask

  task automatic test_tie();
    logic [NP*MW-1:0] want;
    want = TieEn ? {4{8'd1}} : {4{8'd4}};
    apply(1, 0, 0, '0, 0, 0);
    apply(0, 1, 0, pack4(30, 30, 30, 30), 8'd4, 8'd4);
    apply(0, 1, 1, pack4(30, 30, 30, 30), 8'd1, 8'd0);
    checks++; if (best_mv_x !== want) begin errors++; $display("FAIL tie_mvx got %0h want %0h", best_mv_x, want); end
    checks++; if (min_sad !== pack4(30, 30, 30, 30)) begin errors++; $display("FAIL tie_min got %0h want %0h", min_sad, pack4(30, 30, 30, 30)); end
  endtask

  task automatic test_first_all_ones();
    apply(1, 0, 0, '0, 0, 0);
    apply(0, 1, 1, '1, 8'd5, 8'hFA);
    checks++; if (best_mv_x !== {4{8'd5}}) begin errors++; $display("FAIL first_mvx got %0h want 05050505", best_mv_x); end
    checks++; if (best_mv_y !== {4{8'hFA}}) begin errors++; $display("FAIL first_mvy got %0h want fafafafa", best_mv_y); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_done got %b want 1", done); end
    checks++; if (cand_cnt !== 3'd1) begin errors++; $display("FAIL first_cnt got %0d want 1", cand_cnt); end
  endtask

  task automatic test_abort();
    apply(1, 0, 0, '0, 0, 0);
    apply(0, 1, 0, pack4(5, 6, 7, 8), 8'd3, 8'd3);
    apply(0, 1, 0, pack4(4, 6, 9, 1), 8'd2, 8'd2);
    apply(1, 1, 0, pack4(1, 1, 1, 1), 8'd7, 8'd7);
    checks++; if (min_sad !== '1) begin errors++; $display("FAIL abort_min got %0h want all ones", min_sad); end
    checks++; if (best_mv_x !== '0) begin errors++; $display("FAIL abort_mvx got %0h want 0", best_mv_x); end
    checks++; if (cand_cnt !== 3'd0) begin errors++; $display("FAIL abort_cnt got %0d want 0", cand_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
    apply(0, 1, 0, pack4(900, 901, 902, 903), 8'd9, 8'd9);
    checks++; if (min_sad !== pack4(900, 901, 902, 903)) begin errors++; $display("FAIL abort_reload got %0h want %0h", min_sad, pack4(900, 901, 902, 903)); end
    checks++; if (cand_cnt !== 3'd1) begin errors++; $display("FAIL abort_cnt1 got %0d want 1", cand_cnt); end
  endtask

  task automatic test_saturate();
    logic [SW-1:0] es;
    logic [MW-1:0] ex, ey;
    apply(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, (i == 9), pack4(50 + i, 60 - i, 70, 80), 8'(i), 8'(i));
    end
    checks++; if (cand_cnt !== 3'(CMAX)) begin errors++; $display("FAIL sat_cnt got %0d want %0d", cand_cnt, CMAX); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", done); end
    apply(0, 1, 0, pack4(0, 0, 0, 0), 8'd1, 8'd1);
    apply(0, 1, 1, pack4(0, 0, 0, 0), 8'd1, 8'd1);
    checks++; if (cand_cnt !== 3'(CMAX)) begin errors++; $display("FAIL done_ignore_cnt got %0d want %0d", cand_cnt, CMAX); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_ignore_done got %b want 0", done); end
    for (int p = 0; p < NP; p++) begin
      exp_lane(p, es, ex, ey);
      checks++; if (min_sad[p*SW +: SW] !== es) begin errors++; $display("FAIL done_ignore_min p%0d got %0d want %0d", p, min_sad[p*SW +: SW], es); end
      checks++; if (best_mv_x[p*MW +: MW] !== ex) begin errors++; $display("FAIL done_ignore_mvx p%0d got %0h want %0h", p, best_mv_x[p*MW +: MW], ex); end
    end
  endtask

  task automatic test_async_reset();
    apply(1, 0, 0, '0, 0, 0);
    apply(0, 1, 0, pack4(11, 12, 13, 14), 8'd6, 8'd6);
    apply(0, 1, 0, pack4(10, 12, 13, 14), 8'd7, 8'd7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (min_sad !== '1) begin errors++; $display("FAIL arst_min got %0h want all ones", min_sad); end
    checks++; if (best_mv_x !== '0) begin errors++; $display("FAIL arst_mvx got %0h want 0", best_mv_x); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    checks++; if (cand_cnt !== 3'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", cand_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 1, 1, pack4(0, 0, 0, 0), 8'd3, 8'd3);
    checks++; if (cand_cnt !== 3'd0) begin errors++; $display("FAIL idle_ignore_cnt got %0d want 0", cand_cnt); end
    checks++; if (min_sad !== '1) begin errors++; $display("FAIL idle_ignore_min got %0h want all ones", min_sad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [NP*SW-1:0] s;
    logic [SW-1:0]    es;
    logic [MW-1:0]    ex, ey;
    logic             st, v, l;
    apply(1, 0, 0, '0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < NP; p++) begin
        s[p*SW +: SW] = ($urandom_range(0, 7) == 0) ? '1 : SW'($urandom_range(0, 40));
      end
      if (m_state != 1 && $urandom_range(0, 3) == 0) st = 1'b1;
      apply(st, v, l, s, MW'($urandom_range(0, 255)), MW'($urandom_range(0, 255)));
      for (int p = 0; p < NP; p++) begin
        exp_lane(p, es, ex, ey);
        checks++; if (min_sad[p*SW +: SW] !== es) begin errors++; $display("FAIL rand_min c%0d p%0d got %0d want %0d", c, p, min_sad[p*SW +: SW], es); end
        checks++; if (best_mv_x[p*MW +: MW] !== ex) begin errors++; $display("FAIL rand_mvx c%0d p%0d got %0h want %0h", c, p, best_mv_x[p*MW +: MW], ex); end
        checks++; if (best_mv_y[p*MW +: MW] !== ey) begin errors++; $display("FAIL rand_mvy c%0d p%0d got %0h want %0h", c, p, best_mv_y[p*MW +: MW], ey); end
      end
      checks++; if (busy !== (m_state == 1)) begin errors++; $display("FAIL rand_busy c%0d got %b want %b", c, busy, (m_state == 1)); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done c%0d got %b want %b", c, done, m_done); end
      checks++; if (cand_cnt !== 3'(m_cnt)) begin errors++; $display("FAIL rand_cnt c%0d got %0d want %0d", c, cand_cnt, m_cnt); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    sad_valid = 1'b0;
    sad_last  = 1'b0;
    sad_in    = '0;
    mv_x      = '0;
    mv_y      = '0;
    test_reset();
    test_basic();
    test_tie();
    test_first_all_ones();
    test_abort();
    test_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
